cmul_rr_scheduler: RTL and testbench

//  Round-robin scheduler sharing one pipelined complex multiplier among NUM_REQ requesters.
//  - Each requester offers a 64-bit operand pair {real[63:32], imag[31:0]} with a valid/ready handshake.
//  - The scheduler issues at most one pair per cycle and drives the multiplier clock enable.
//  - It tracks a requester tag through the multiplier latency and returns each result tagged with its source.

---
 rtl/cmul_rr_scheduler.sv | 147 ++++++++++++++
 tb/tb_cmul_rr_scheduler.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cmul_rr_scheduler.sv
// cmul_rr_scheduler
//   Round-robin scheduler that shares one pipelined complex multiplier
//   among NUM_REQ requesters. Operand pairs are {real[63:32], imag[31:0]}.
//   One pair is issued per cycle at most. A source tag travels alongside
//   each operation through the multiplier latency. The whole pipeline
//   freezes while a result is held off by the consumer.
//
// Optional feature macro: CMUL_MODE_SEL_EN
//   When it is defined, the block adds per-requester multiply-mode select:
//   req_conj in, mul_conj out, and res_conj out aligned with res_valid.
//   When it is undefined, the multiplier is fixed conjugate-conjugate.
//
// Ports
//   clk, rst_n  clock (rising edge), asynchronous active-low reset
//   req_valid   per-requester operand pair valid
//   req_ready   one-hot grant (transfer on valid & ready)
//   req_a/req_b per-requester operands, requester i at [64*i +: 64]
//   mul_a/mul_b operands muxed from the winner to the multiplier
//   mul_ce      multiplier clock enable
//   mul_result  multiplier output
//   res_valid   result valid; res_ready is the consumer accept
//   res_data    mul_result passed through
//   res_tag     index of the requester that issued the result
//   busy        one or more operations in flight
module cmul_rr_scheduler #(
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned MUL_LATENCY = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [NUM_REQ*64-1:0]      req_a,
  input  logic [NUM_REQ*64-1:0]      req_b,
`ifdef CMUL_MODE_SEL_EN
  input  logic [NUM_REQ-1:0]         req_conj,
  output logic                       mul_conj,
  output logic                       res_conj,
`endif
  output logic [63:0]                mul_a,
  output logic [63:0]                mul_b,
  output logic                       mul_ce,
  input  logic [63:0]                mul_result,
  output logic                       res_valid,
  input  logic                       res_ready,
  output logic [63:0]                res_data,
  output logic [$clog2(NUM_REQ)-1:0] res_tag,
  output logic                       busy
);

  localparam int unsigned TAG_W = $clog2(NUM_REQ);

  logic [TAG_W-1:0]       ptr;
  logic [TAG_W-1:0]       win;
  logic [TAG_W-1:0]       idx;
  logic [TAG_W-1:0]       sel;
  logic                   found;
  logic                   any_valid;
  logic                   issue;
  logic [MUL_LATENCY-1:0] vld_sr;
  logic [TAG_W-1:0]       tag_sr [MUL_LATENCY];
`ifdef CMUL_MODE_SEL_EN
  logic [MUL_LATENCY-1:0] conj_sr;
`endif

  // Backpressure on a pending result freezes the multiplier and all tracking.
  assign mul_ce    = !(res_valid && !res_ready);
  assign any_valid = |req_valid;
  assign issue     = mul_ce && any_valid;

  // Round-robin search starting just after the last winner, wrapping.
  always_comb begin
    win   = ptr;
    found = 1'b0;
    idx   = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      idx = TAG_W'((32'(ptr) + k) % NUM_REQ);
      if (!found && req_valid[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
  end

  // Grant only while running and out of reset, so held requests are not consumed.
  assign req_ready = (issue && rst_n) ? (NUM_REQ'(1) << win) : '0;

  // With no request, ptr still names the last winner, so its operands hold.
  assign sel = any_valid ? win : ptr;

  // Operand mux onto the shared multiplier.
  always_comb begin
    mul_a = '0;
    mul_b = '0;
`ifdef CMUL_MODE_SEL_EN
    mul_conj = 1'b0;
`endif
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (TAG_W'(i) == sel) begin
        mul_a = req_a[i*64 +: 64];
        mul_b = req_b[i*64 +: 64];
`ifdef CMUL_MODE_SEL_EN
        mul_conj = req_conj[i];
`endif
      end
    end
  end

  // Pointer and valid/tag shift registers, advancing only with the multiplier.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr    <= TAG_W'(NUM_REQ - 1);
      vld_sr <= '0;
      for (int unsigned i = 0; i < MUL_LATENCY; i++) begin
        tag_sr[i] <= '0;
      end
`ifdef CMUL_MODE_SEL_EN
      conj_sr <= '0;
`endif
    end else if (mul_ce) begin
      if (issue) begin
        ptr <= win;
      end
      vld_sr[0] <= issue;
      tag_sr[0] <= issue ? win : '0;
`ifdef CMUL_MODE_SEL_EN
      conj_sr[0] <= issue ? mul_conj : 1'b0;
`endif
      for (int unsigned i = 1; i < MUL_LATENCY; i++) begin
        vld_sr[i] <= vld_sr[i-1];
        tag_sr[i] <= tag_sr[i-1];
`ifdef CMUL_MODE_SEL_EN
        conj_sr[i] <= conj_sr[i-1];
`endif
      end
    end
  end

  assign res_valid = vld_sr[MUL_LATENCY-1];
  assign res_tag   = tag_sr[MUL_LATENCY-1];
  assign res_data  = mul_result;
  assign busy      = |vld_sr;
`ifdef CMUL_MODE_SEL_EN
  assign res_conj  = conj_sr[MUL_LATENCY-1];
`endif

endmodule

// File: tb/tb_cmul_rr_scheduler.sv
// tb_cmul_rr_scheduler
//   Directed bench for cmul_rr_scheduler with a ce-gated multiplier model.
//   The model returns the hand-computed IEEE single product for the known
//   operand pair and a simple bit pattern for other operands. This lets
//   every result be traced back to its source.
module tb_cmul_rr_scheduler;

  localparam int unsigned NUM = 4;
  localparam int unsigned LAT = 8;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NUM-1:0]    req_valid;
  logic [NUM-1:0]    req_ready;
  logic [NUM*64-1:0] req_a;
  logic [NUM*64-1:0] req_b;
  logic [63:0]       mul_a;
  logic [63:0]       mul_b;
  logic              mul_ce;
  logic [63:0]       mul_result;
  logic              res_valid;
  logic              res_ready;
  logic [63:0]       res_data;
  logic [1:0]        res_tag;
  logic              busy;
  logic              m_conj;
`ifdef CMUL_MODE_SEL_EN
  logic [NUM-1:0]    req_conj;
  logic              mul_conj;
  logic              res_conj;
  assign m_conj = mul_conj;
`else
  assign m_conj = 1'b1;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [63:0] SPEC_A = 64'h3F800000_40000000;
  localparam logic [63:0] SPEC_B = 64'h40400000_40800000;
`ifdef CMUL_MODE_SEL_EN
  localparam logic [63:0] SPEC_P = 64'hC0A00000_41200000;
`else
  localparam logic [63:0] SPEC_P = 64'hC0A00000_C1200000;
`endif

  cmul_rr_scheduler #(.NUM_REQ(NUM), .MUL_LATENCY(LAT)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
`ifdef CMUL_MODE_SEL_EN
    .req_conj   (req_conj),
    .mul_conj   (mul_conj),
    .res_conj   (res_conj),
`endif
    .mul_a      (mul_a),
    .mul_b      (mul_b),
    .mul_ce     (mul_ce),
    .mul_result (mul_result),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_data   (res_data),
    .res_tag    (res_tag),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] cmul_model(input logic [63:0] a, input logic [63:0] b,
                                             input logic conj);
    if (a == SPEC_A && b == SPEC_B)
      return conj ? 64'hC0A00000_C1200000 : 64'hC0A00000_41200000;
    return a ^ {b[31:0], b[63:32]};
  endfunction

  function automatic logic [63:0] opa(input int i);
    return {32'h1111_0000 + 32'(i), 32'h2222_0000 + 32'(i)};
  endfunction

  function automatic logic [63:0] opb(input int i);
    return {32'h0300_0000 + 32'(i << 4), 32'h0040_0000};
  endfunction

  // External multiplier: LAT stages, advancing only on mul_ce.
  logic [63:0] mpipe [LAT];
  always @(posedge clk) begin
    if (mul_ce) begin
      mpipe[0] <= cmul_model(mul_a, mul_b, m_conj);
      for (int i = 1; i < int'(LAT); i++) mpipe[i] <= mpipe[i-1];
    end
  end
  assign mul_result = mpipe[LAT-1];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic load_ops();
    for (int i = 0; i < int'(NUM); i++) begin
      req_a[i*64 +: 64] = opa(i);
      req_b[i*64 +: 64] = opb(i);
    end
  endtask

  int miss;
  int n2;
  logic [NUM-1:0] g;

  initial begin
    for (int i = 0; i < int'(LAT); i++) mpipe[i] = '0;
    rst_n     = 1'b0;
    req_valid = 4'hF;
    res_ready = 1'b1;
    load_ops();
`ifdef CMUL_MODE_SEL_EN
    req_conj = '0;
`endif
    #12;
    // Reset state
    check("rst_req_ready", 64'(req_ready), 64'h0);
    check("rst_res_valid", 64'(res_valid), 64'h0);
    check("rst_busy",      64'(busy),      64'h0);
    check("rst_res_tag",   64'(res_tag),   64'h0);
    req_valid = '0;
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // Single issue from requester 0
    req_a[63:0] = SPEC_A;
    req_b[63:0] = SPEC_B;
    req_valid   = 4'b0001;
    #1;
    check("single_grant", 64'(req_ready), 64'h1);
    check("single_mul_a", mul_a, SPEC_A);
    step();
    req_valid = '0;
    #1;
    check("single_grant_drop", 64'(req_ready), 64'h0);
    check("single_busy",       64'(busy),      64'h1);
    check("single_hold_a",     mul_a,          SPEC_A);
    for (int e = 2; e <= 7; e++) begin
      step();
      check("single_early", 64'(res_valid), 64'h0);
    end
    step();
    check("single_valid", 64'(res_valid), 64'h1);
    check("single_tag",   64'(res_tag),   64'h0);
    check("single_data",  res_data,       SPEC_P);
`ifdef CMUL_MODE_SEL_EN
    check("single_conj",  64'(res_conj),  64'h0);
`endif
    step();
    check("single_done_valid", 64'(res_valid), 64'h0);
    check("single_done_busy",  64'(busy),      64'h0);
    load_ops();

    // Fresh pointer, then contention with all requesters valid
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    for (int c = 0; c < 8; c++) begin
      req_valid = 4'hF;
      #1;
      check("cont_grant", 64'(req_ready), 64'(4'b0001 << (c % 4)));
      step();
    end
    req_valid = '0;
    for (int r = 0; r < 8; r++) begin
      check("cont_res_valid", 64'(res_valid), 64'h1);
      check("cont_res_tag",   64'(res_tag),   64'(r % 4));
      check("cont_res_data",  res_data,       cmul_model(opa(r % 4), opb(r % 4), 1'b1));
      step();
    end
    check("cont_drained", 64'(res_valid), 64'h0);

    // Backpressure: last winner was 3, so grants go 0,1,2
    for (int c = 0; c < 3; c++) begin
      req_valid = 4'hF;
      #1;
      check("bp_grant", 64'(req_ready), 64'(4'b0001 << c));
      step();
    end
    req_valid = '0;
    repeat (5) step();
    check("bp_first_valid", 64'(res_valid), 64'h1);
    res_ready = 1'b0;
    req_valid = 4'hF;
    #1;
    check("bp_ce",    64'(mul_ce),    64'h0);
    check("bp_ready", 64'(req_ready), 64'h0);
    for (int s = 0; s < 5; s++) begin
      step();
      check("bp_hold_valid", 64'(res_valid), 64'h1);
      check("bp_hold_tag",   64'(res_tag),   64'h0);
      check("bp_hold_data",  res_data,       cmul_model(opa(0), opb(0), 1'b1));
      check("bp_hold_ce",    64'(mul_ce),    64'h0);
      check("bp_hold_ready", 64'(req_ready), 64'h0);
    end
    req_valid = '0;
    res_ready = 1'b1;
    #1;
    for (int r = 0; r < 3; r++) begin
      check("bp_rel_valid", 64'(res_valid), 64'h1);
      check("bp_rel_tag",   64'(res_tag),   64'(r));
      step();
    end
    check("bp_rel_done",  64'(res_valid), 64'h0);
    check("bp_rel_busy",  64'(busy),      64'h0);

    // Fairness: req2 held, req0 toggling
    miss = 0;
    n2   = 0;
    for (int c = 0; c < 100; c++) begin
      req_valid = (c % 2 == 0) ? 4'b0101 : 4'b0100;
      #1;
      g = req_ready;
      if (g == 4'b0100) begin
        miss = 0;
        n2++;
      end else begin
        miss++;
      end
      check("fair_onehot", 64'(g == 4'b0100 || g == 4'b0001), 64'h1);
      check("fair_gap",    64'(miss <= 1),                    64'h1);
      step();
    end
    check("fair_count", 64'(n2 >= 50), 64'h1);
    req_valid = '0;
    repeat (10) step();
    check("fair_drain_busy", 64'(busy), 64'h0);

    // Reset with three operations in flight
    req_valid = 4'hF;
    repeat (3) step();
    req_valid = 4'b1010;
    check("mid_busy_before", 64'(busy), 64'h1);
    rst_n = 1'b0;
    #1;
    check("mid_res_valid", 64'(res_valid), 64'h0);
    check("mid_busy",      64'(busy),      64'h0);
    check("mid_ready",     64'(req_ready), 64'h0);
    step();
    check("mid_ready_hold", 64'(req_ready), 64'h0);
    rst_n = 1'b1;
    #1;
    check("mid_first_grant", 64'(req_ready), 64'b0010);
    step();
    req_valid = '0;
    check("mid_busy_after", 64'(busy), 64'h1);
    for (int e = 2; e <= 7; e++) begin
      step();
      check("mid_no_stale", 64'(res_valid), 64'h0);
    end
    step();
    check("mid_res_valid_new", 64'(res_valid), 64'h1);
    check("mid_res_tag_new",   64'(res_tag),   64'h1);
    step();
    check("mid_res_done", 64'(res_valid), 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
